// File: rtl/apb_up_gpio.sv
// APB GPIO: NUM_PINS pads with direction/output registers, atomic set/clear/toggle,
// synchronised inputs and per-pin edge/level interrupts. Optional debounce: UP_GPIO_DEBOUNCE_EN.
module apb_up_gpio #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_PINS       = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_PINS-1:0]       upio_in_i,
  output logic [NUM_PINS-1:0]       upio_out_o,
  output logic [NUM_PINS-1:0]       upio_dir_o,
  output logic                      int_o
);

  localparam logic [3:0] A_PADDIR    = 4'd0;
  localparam logic [3:0] A_PADIN     = 4'd1;
  localparam logic [3:0] A_PADOUT    = 4'd2;
  localparam logic [3:0] A_OUTSET    = 4'd3;
  localparam logic [3:0] A_OUTCLR    = 4'd4;
  localparam logic [3:0] A_OUTTGL    = 4'd5;
  localparam logic [3:0] A_INTEN     = 4'd6;
  localparam logic [3:0] A_INTTYPE0  = 4'd7;
  localparam logic [3:0] A_INTTYPE1  = 4'd8;
  localparam logic [3:0] A_INTSTATUS = 4'd9;
  localparam logic [3:0] A_CTRL      = 4'd10;
  localparam logic [3:0] A_DBCFG     = 4'd11;

  function automatic logic [31:0] zext(input logic [NUM_PINS-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[NUM_PINS-1:0] = v;
    return r;
  endfunction

  logic                wr_s;
  logic [3:0]          idx_s;
  logic [NUM_PINS-1:0] wdata_s;
  logic [NUM_PINS-1:0] dir_r, out_r, inten_r, type0_r, type1_r, status_r;
  logic                gie_r;
  logic [NUM_PINS-1:0] sync1_r, sync2_r, prev_r, filt_s;
  logic [1:0]          start_cnt_r;
  logic                edge_en_s;
  logic [NUM_PINS-1:0] edge_raw_s, edge_trig_s, level_trig_s, clr_s;
  logic [31:0]         dbcfg_rd_s;
  logic                unused_s;

  assign wr_s     = PSEL & PENABLE & PWRITE;
  assign idx_s    = PADDR[5:2];
  assign wdata_s  = PWDATA[NUM_PINS-1:0];
  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign unused_s = ^{PADDR, PWDATA};

  // Two-flop synchroniser and edge-detect history
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
    end else begin
      sync1_r <= upio_in_i;
      sync2_r <= sync1_r;
      prev_r  <= filt_s;
    end
  end

`ifdef UP_GPIO_DEBOUNCE_EN
  logic [15:0]         dbcfg_r, tick_cnt_r;
  logic                tick_s;
  logic [NUM_PINS-1:0] s0_r, s1_r, s2_r, filt_r;

  assign tick_s     = (tick_cnt_r == dbcfg_r);
  assign filt_s     = filt_r;
  assign dbcfg_rd_s = {16'd0, dbcfg_r};

  // Shared prescaler and per-pin 3-sample majority-free agreement filter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dbcfg_r    <= 16'd0;
      tick_cnt_r <= 16'd0;
      s0_r       <= '0;
      s1_r       <= '0;
      s2_r       <= '0;
      filt_r     <= '0;
    end else begin
      if (wr_s && (idx_s == A_DBCFG)) begin
        dbcfg_r    <= PWDATA[15:0];
        tick_cnt_r <= 16'd0;
      end else if (tick_s) begin
        tick_cnt_r <= 16'd0;
      end else begin
        tick_cnt_r <= tick_cnt_r + 16'd1;
      end
      if (tick_s) begin
        s0_r <= sync2_r;
        s1_r <= s0_r;
        s2_r <= s1_r;
      end
      // Go high when all samples are 1, low when all are 0, otherwise hold
      filt_r <= (s0_r & s1_r & s2_r) | (filt_r & (s0_r | s1_r | s2_r));
    end
  end
`else
  assign filt_s     = sync2_r;
  assign dbcfg_rd_s = 32'd0;
`endif

  // Startup mask keeps pads held high through reset from looking like rising edges
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      start_cnt_r <= 2'd0;
    end else if (start_cnt_r != 2'd3) begin
      start_cnt_r <= start_cnt_r + 2'd1;
    end else begin
      start_cnt_r <= start_cnt_r;
    end
  end

  assign edge_en_s = (start_cnt_r == 2'd3);

  // Per-pin trigger selection
  always_comb begin
    edge_raw_s   = '0;
    level_trig_s = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      case ({type1_r[i], type0_r[i]})
        2'b00:   edge_raw_s[i]   = filt_s[i] & ~prev_r[i];
        2'b01:   edge_raw_s[i]   = ~filt_s[i] & prev_r[i];
        2'b10:   edge_raw_s[i]   = filt_s[i] ^ prev_r[i];
        2'b11:   level_trig_s[i] = filt_s[i];
        default: edge_raw_s[i]   = 1'b0;
      endcase
    end
  end

  assign edge_trig_s = edge_raw_s & {NUM_PINS{edge_en_s}};
  assign clr_s       = (wr_s && (idx_s == A_INTSTATUS)) ? wdata_s : '0;

  // Register file; an edge trigger beats a same-cycle clear, a level trigger re-arms one cycle later
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dir_r    <= '0;
      out_r    <= '0;
      inten_r  <= '0;
      type0_r  <= '0;
      type1_r  <= '0;
      gie_r    <= 1'b0;
      status_r <= '0;
    end else begin
      status_r <= (status_r & ~clr_s) | edge_trig_s | (level_trig_s & ~clr_s);
      if (wr_s) begin
        case (idx_s)
          A_PADDIR:   dir_r   <= wdata_s;
          A_PADOUT:   out_r   <= wdata_s;
          A_OUTSET:   out_r   <= out_r | wdata_s;
          A_OUTCLR:   out_r   <= out_r & ~wdata_s;
          A_OUTTGL:   out_r   <= out_r ^ wdata_s;
          A_INTEN:    inten_r <= wdata_s;
          A_INTTYPE0: type0_r <= wdata_s;
          A_INTTYPE1: type1_r <= wdata_s;
          A_CTRL:     gie_r   <= PWDATA[0];
          default:    ;
        endcase
      end
    end
  end

  // Read mux, combinational from PADDR
  always_comb begin
    case (idx_s)
      A_PADDIR:    PRDATA = zext(dir_r);
      A_PADIN:     PRDATA = zext(filt_s);
      A_PADOUT:    PRDATA = zext(out_r);
      A_INTEN:     PRDATA = zext(inten_r);
      A_INTTYPE0:  PRDATA = zext(type0_r);
      A_INTTYPE1:  PRDATA = zext(type1_r);
      A_INTSTATUS: PRDATA = zext(status_r);
      A_CTRL:      PRDATA = {31'd0, gie_r};
      A_DBCFG:     PRDATA = dbcfg_rd_s;
      default:     PRDATA = 32'd0;
    endcase
  end

  assign upio_out_o = out_r;
  assign upio_dir_o = dir_r;
  assign int_o      = gie_r & (|(status_r & inten_r));

endmodule

// File: tb/tb_apb_up_gpio.sv
// Directed self-checking bench for apb_up_gpio (default NUM_PINS = 8).
module tb_apb_up_gpio;

`ifdef UP_GPIO_DEBOUNCE_EN
  localparam int DL = 4;
`else
  localparam int DL = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  upio_in, upio_out, upio_dir;
  logic        int_o;
  logic [31:0] d;
  int          checks = 0;
  int          errors = 0;

  apb_up_gpio #(.APB_ADDR_WIDTH(12), .NUM_PINS(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .upio_in_i(upio_in),
    .upio_out_o(upio_out), .upio_dir_o(upio_dir), .int_o(int_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge HCLK);
    PADDR = a[11:0]; PWDATA = v; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(posedge HCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    PADDR = a[11:0]; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    #1;
    v = PRDATA;
    PSEL = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; PADDR = 12'd0; PWDATA = 32'd0; PWRITE = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; upio_in = 8'h00;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;

    // reset state
    for (int a = 0; a < 12; a++) begin
      peek(a * 4, d);
      check($sformatf("rst_rd_%02h", a * 4), d, 32'd0);
    end
    check("rst_dir", {24'd0, upio_dir}, 32'd0);
    check("rst_out", {24'd0, upio_out}, 32'd0);
    check("rst_int", {31'd0, int_o}, 32'd0);
    check("pready", {30'd0, PREADY, PSLVERR}, 32'd2);

    // output register and atomic ops
    apb_write(32'h08, 32'hA5);
    check("out_wr", {24'd0, upio_out}, 32'hA5);
    apb_write(32'h0C, 32'h0A);
    peek(32'h08, d); check("outset_rd", d, 32'hAF);
    check("outset_pad", {24'd0, upio_out}, 32'hAF);
    apb_write(32'h10, 32'h81);
    peek(32'h08, d); check("outclr_rd", d, 32'h2E);
    check("outclr_pad", {24'd0, upio_out}, 32'h2E);
    apb_write(32'h14, 32'hFF);
    peek(32'h08, d); check("outtgl_rd", d, 32'hD1);
    check("outtgl_pad", {24'd0, upio_out}, 32'hD1);
    peek(32'h0C, d); check("wo_reads0", d, 32'd0);

    // direction, upper bits dropped, unmapped offsets
    apb_write(32'h00, 32'h12345678);
    peek(32'h00, d); check("dir_rd", d, 32'h78);
    check("dir_pad", {24'd0, upio_dir}, 32'h78);
    apb_write(32'h00, 32'h0);
    apb_write(32'h30, 32'hFFFFFFFF);
    peek(32'h30, d); check("unmapped", d, 32'd0);
`ifndef UP_GPIO_DEBOUNCE_EN
    apb_write(32'h2C, 32'h4);
    peek(32'h2C, d); check("dbcfg_absent", d, 32'd0);
`endif

    // pin 3 rising edge
    apb_write(32'h18, 32'h08);
    apb_write(32'h28, 32'h01);
    @(negedge HCLK); upio_in[3] = 1'b1;
    @(posedge HCLK);
    repeat (DL) @(posedge HCLK);
    @(posedge HCLK); #1;
    peek(32'h04, d); check("p3_padin", d, 32'h08);
    peek(32'h24, d); check("p3_not_yet", d, 32'h00);
    @(posedge HCLK); #1;
    peek(32'h24, d); check("p3_status", d, 32'h08);
    check("p3_int", {31'd0, int_o}, 32'd1);
    apb_write(32'h28, 32'h00);
    check("gie_off", {31'd0, int_o}, 32'd0);
    apb_write(32'h28, 32'h01);
    check("gie_on", {31'd0, int_o}, 32'd1);
    apb_write(32'h24, 32'h08);
    check("p3_w1c_int", {31'd0, int_o}, 32'd0);
    peek(32'h24, d); check("p3_w1c", d, 32'h00);
    upio_in[3] = 1'b0;
    repeat (4 + DL) @(posedge HCLK); #1;
    peek(32'h24, d); check("p3_fall", d, 32'h00);

    // pin 0 level-high
    apb_write(32'h1C, 32'h01);
    apb_write(32'h20, 32'h01);
    upio_in[0] = 1'b1;
    repeat (3 + DL) @(posedge HCLK); #1;
    peek(32'h24, d); check("p0_level", d, 32'h01);
    apb_write(32'h24, 32'h01);
    peek(32'h24, d); check("p0_cleared", d, 32'h00);
    @(posedge HCLK); #1;
    peek(32'h24, d); check("p0_reset", d, 32'h01);
    upio_in[0] = 1'b0;
    repeat (3 + DL) @(posedge HCLK); #1;
    apb_write(32'h24, 32'h01);
    peek(32'h24, d); check("p0_low_clr", d, 32'h00);
    repeat (2) @(posedge HCLK); #1;
    peek(32'h24, d); check("p0_stays0", d, 32'h00);

    // pin 7 both edges, trigger collides with W1C
    apb_write(32'h20, 32'h81);
    upio_in[7] = 1'b1;
    repeat (3 + DL) @(posedge HCLK); #1;
    peek(32'h24, d); check("p7_rise", d, 32'h80);
    @(negedge HCLK); upio_in[7] = 1'b0;
    repeat (DL) @(negedge HCLK);
    apb_write(32'h24, 32'h80);
    peek(32'h24, d); check("p7_set_wins", d, 32'h80);
    apb_write(32'h24, 32'h80);
    peek(32'h24, d); check("p7_w1c", d, 32'h00);

    // asynchronous reset mid-operation, then pads held high through reset
    upio_in = 8'hFF;
    repeat (3 + DL) @(posedge HCLK); #1;
    peek(32'h24, d); check("all_status", d, 32'hFF);
    check("all_int", {31'd0, int_o}, 32'd1);
    HRESETn = 1'b0;
    #1;
    peek(32'h24, d); check("arst_status", d, 32'h00);
    check("arst_int", {31'd0, int_o}, 32'd0);
    check("arst_out", {24'd0, upio_out}, 32'd0);
    repeat (3) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    repeat (8) @(posedge HCLK); #1;
    peek(32'h04, d); check("held_padin", d, 32'hFF);
`ifndef UP_GPIO_DEBOUNCE_EN
    peek(32'h24, d); check("held_no_edge", d, 32'h00);
`endif

`ifdef UP_GPIO_DEBOUNCE_EN
    // debounce with prescale 4
    upio_in = 8'h00;
    apb_write(32'h2C, 32'h4);
    peek(32'h2C, d); check("dbcfg_rd", d, 32'h4);
    repeat (40) @(posedge HCLK); #1;
    apb_write(32'h24, 32'hFF);
    apb_write(32'h18, 32'h02);
    apb_write(32'h28, 32'h01);
    peek(32'h04, d); check("db_idle", d, 32'h00);
    upio_in[1] = 1'b1;
    repeat (7) @(posedge HCLK); #1;
    upio_in[1] = 1'b0;
    repeat (30) @(posedge HCLK); #1;
    peek(32'h04, d); check("db_glitch_padin", d, 32'h00);
    peek(32'h24, d); check("db_glitch_status", d, 32'h00);
    check("db_glitch_int", {31'd0, int_o}, 32'd0);
    upio_in[1] = 1'b1;
    repeat (20) @(posedge HCLK); #1;
    peek(32'h04, d); check("db_held_padin", d, 32'h02);
    peek(32'h24, d); check("db_held_status", d, 32'h02);
    check("db_held_int", {31'd0, int_o}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
